// File: rtl/timer_mmio.sv
// timer_mmio: memory-mapped 16-bit prescaled timer with compare match,
// optional auto-reload, sticky match flag and a registered interrupt.
// Read data is forced to zero outside the 16-byte window so the bus can
// OR this responder's output with the others.
module timer_mmio #(
  parameter logic [8:0] BASE_ADDR = 9'h1F0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rw,
  input  logic [8:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       hit,
  output logic       irq
);

  // Register state
  logic [2:0]  r_ctrl;       // bit0 enable, bit1 auto_reload, bit2 irq_en
  logic [7:0]  r_prescale;
  logic [7:0]  r_pcnt;
  logic [15:0] r_count;
  logic [15:0] r_cmp;
  logic        r_match;
  logic [7:0]  r_hi_shadow;
  logic [7:0]  r_data_out;
  logic        r_hit;
  logic        r_irq;

  // Decode and datapath helpers
  logic       w_sel;
  logic [3:0] w_off;
  logic       w_wr;
  logic       w_rd;
  logic       w_wr_ctrl;
  logic       w_wr_pre;
  logic       w_wr_lo;
  logic       w_wr_hi;
  logic       w_wr_cmp_lo;
  logic       w_wr_cmp_hi;
  logic       w_wr_status;
  logic       w_count_wr;
  logic       w_tick;
  logic       w_cmp_eq;
  logic       w_match_set;
  logic [7:0] w_rd_data;

  assign w_sel       = (address[8:4] == BASE_ADDR[8:4]);
  assign w_off       = address[3:0];
  assign w_wr        = rw & w_sel;
  assign w_rd        = ~rw & w_sel;
  assign w_wr_ctrl   = w_wr & (w_off == 4'h0);
  assign w_wr_pre    = w_wr & (w_off == 4'h1);
  assign w_wr_lo     = w_wr & (w_off == 4'h2);
  assign w_wr_hi     = w_wr & (w_off == 4'h3);
  assign w_wr_cmp_lo = w_wr & (w_off == 4'h4);
  assign w_wr_cmp_hi = w_wr & (w_off == 4'h5);
  assign w_wr_status = w_wr & (w_off == 4'h6);
  assign w_count_wr  = w_wr_lo | w_wr_hi;
  assign w_tick      = r_ctrl[0] & (r_pcnt == r_prescale);
  assign w_cmp_eq    = (r_count == r_cmp);
  // A counter load suppresses the tick entirely, including match evaluation.
  assign w_match_set = w_tick & ~w_count_wr & w_cmp_eq;

  assign data_out = r_data_out;
  assign hit      = r_hit;
  assign irq      = r_irq;

  // Read multiplexer over the register window (values before this edge).
  always_comb begin
    w_rd_data = 8'h00;
    case (w_off)
      4'h0:    w_rd_data = {5'b00000, r_ctrl};
      4'h1:    w_rd_data = r_prescale;
      4'h2:    w_rd_data = r_count[7:0];
      4'h3:    w_rd_data = r_hi_shadow;
      4'h4:    w_rd_data = r_cmp[7:0];
      4'h5:    w_rd_data = r_cmp[15:8];
      4'h6:    w_rd_data = {7'b0000000, r_match};
      default: w_rd_data = 8'h00;
    endcase
  end

  // Configuration registers: CTRL, PRESCALE and the compare value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl     <= 3'b000;
      r_prescale <= 8'h00;
      r_cmp      <= 16'hFFFF;
    end else begin
      if (w_wr_ctrl)   r_ctrl        <= data_in[2:0];
      if (w_wr_pre)    r_prescale    <= data_in;
      if (w_wr_cmp_lo) r_cmp[7:0]    <= data_in;
      if (w_wr_cmp_hi) r_cmp[15:8]   <= data_in;
    end
  end

  // Prescaler: cleared when disabled or on a counter load, else wraps at PRESCALE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= 8'h00;
    end else if (w_count_wr || !r_ctrl[0] || w_tick) begin
      r_pcnt <= 8'h00;
    end else begin
      r_pcnt <= r_pcnt + 8'd1;
    end
  end

  // Counter: bus loads take priority over ticks; auto-reload on compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 16'h0000;
    end else if (w_count_wr) begin
      if (w_wr_lo) r_count[7:0]  <= data_in;
      if (w_wr_hi) r_count[15:8] <= data_in;
    end else if (w_tick) begin
      if (w_cmp_eq && r_ctrl[1]) r_count <= 16'h0000;
      else                       r_count <= r_count + 16'd1;
    end
  end

  // Sticky match flag: a new match beats a same-cycle write-1-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match <= 1'b0;
    end else if (w_match_set) begin
      r_match <= 1'b1;
    end else if (w_wr_status && data_in[0]) begin
      r_match <= 1'b0;
    end
  end

  // High-byte shadow captured on any COUNT_LO read for a coherent 16-bit read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi_shadow <= 8'h00;
    end else if (w_rd && (w_off == 4'h2)) begin
      r_hi_shadow <= r_count[15:8];
    end
  end

  // Registered bus response and interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= 8'h00;
      r_hit      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_hit      <= w_sel;
      r_data_out <= w_rd ? w_rd_data : 8'h00;
      r_irq      <= r_match & r_ctrl[2];
    end
  end

endmodule

// File: tb/tb_timer_mmio.sv
// Directed self-checking bench for timer_mmio. Each bus operation occupies
// exactly one rising edge; outputs are sampled 1 time unit after that edge.
module tb_timer_mmio;

  logic       clk;
  logic       reset;
  logic       rw;
  logic [8:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       hit;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_mmio #(.BASE_ADDR(9'h1F0)) dut (
    .clk      (clk),
    .reset    (reset),
    .rw       (rw),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .hit      (hit),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    rw = 1'b1; address = a; data_in = d;
    @(posedge clk);
    #1;
    rw = 1'b0; address = 9'h000; data_in = 8'h00;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [7:0] d, output logic h);
    @(negedge clk);
    rw = 1'b0; address = a;
    @(posedge clk);
    #1;
    d = data_out; h = hit;
    address = 9'h000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic h;
    bus_write(9'h1F1, 8'h03);
    bus_write(9'h1F4, 8'h02);
    bus_write(9'h1F5, 8'h00);
    bus_write(9'h1F0, 8'h05);
    idle(20);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL rst_pre_irq got=%b exp=%b", irq, 1'b1); end
    bus_read(9'h1F0, d, h);
    n_checks++;
    if (d !== 8'h05) begin n_fail++; $display("FAIL rst_pre_ctrl got=%h exp=%h", d, 8'h05); end
    // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (data_out !== 8'h00 || irq !== 1'b0 || hit !== 1'b0) begin
      n_fail++; $display("FAIL rst_async got=%h/%b/%b exp=00/0/0", data_out, irq, hit);
    end
    @(negedge clk);
    reset = 1'b0;
    bus_read(9'h1F2, d, h);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL rst_cnt_lo got=%h exp=%h", d, 8'h00); end
    bus_read(9'h1F3, d, h);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL rst_cnt_hi got=%h exp=%h", d, 8'h00); end
    bus_read(9'h1F4, d, h);
    n_checks++;
    if (d !== 8'hFF) begin n_fail++; $display("FAIL rst_cmp_lo got=%h exp=%h", d, 8'hFF); end
    bus_read(9'h1F5, d, h);
    n_checks++;
    if (d !== 8'hFF) begin n_fail++; $display("FAIL rst_cmp_hi got=%h exp=%h", d, 8'hFF); end
    bus_read(9'h1F1, d, h);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL rst_prescale got=%h exp=%h", d, 8'h00); end
    bus_read(9'h1F6, d, h);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL rst_status got=%h exp=%h", d, 8'h00); end
  endtask

  task automatic test_prescale();
    logic [7:0] d; logic h;
    pulse_reset();
    bus_write(9'h1F1, 8'h03);
    bus_write(9'h1F0, 8'h01);          // enable at edge E; ticks at E+4k
    idle(40);
    bus_read(9'h1F2, d, h);            // count after E+40 = 10
    n_checks++;
    if (d !== 8'h0A) begin n_fail++; $display("FAIL pre_cnt_lo got=%h exp=%h", d, 8'h0A); end
    bus_read(9'h1F3, d, h);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL pre_cnt_hi got=%h exp=%h", d, 8'h00); end
    // Shadow coherence across a high-byte carry.
    bus_write(9'h1F0, 8'h00);
    bus_write(9'h1F2, 8'hFE);
    bus_write(9'h1F3, 8'h01);
    bus_write(9'h1F1, 8'h00);
    bus_write(9'h1F0, 8'h01);          // edge E, tick every edge after
    bus_read(9'h1F2, d, h);            // E+1: 0x01FE
    n_checks++;
    if (d !== 8'hFE) begin n_fail++; $display("FAIL shd_lo0 got=%h exp=%h", d, 8'hFE); end
    idle(3);
    bus_read(9'h1F3, d, h);            // E+5: shadow still 0x01
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL shd_hold got=%h exp=%h", d, 8'h01); end
    bus_read(9'h1F2, d, h);            // E+6: count after E+5 = 0x0203
    n_checks++;
    if (d !== 8'h03) begin n_fail++; $display("FAIL shd_lo1 got=%h exp=%h", d, 8'h03); end
    bus_read(9'h1F3, d, h);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL shd_hi1 got=%h exp=%h", d, 8'h02); end
  endtask

  task automatic test_compare_reload();
    logic [7:0] d; logic h; logic [7:0] exp_c; logic exp_i;
    pulse_reset();
    bus_write(9'h1F4, 8'h05);
    bus_write(9'h1F5, 8'h00);
    bus_write(9'h1F0, 8'h07);          // edge E
    for (int k = 1; k <= 8; k++) begin
      bus_read(9'h1F2, d, h);          // count after E+k-1
      exp_c = (k == 7) ? 8'h00 : (k == 8) ? 8'h01 : 8'(k - 1);
      exp_i = (k >= 7);
      n_checks++;
      if (d !== exp_c || irq !== exp_i) begin
        n_fail++; $display("FAIL reload_seq k=%0d got=%h/%b exp=%h/%b", k, d, irq, exp_c, exp_i);
      end
    end
    bus_read(9'h1F6, d, h);            // E+9
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL match_set got=%h exp=%h", d, 8'h01); end
    bus_write(9'h1F6, 8'h01);          // E+10: plain clear
    bus_read(9'h1F6, d, h);            // E+11
    n_checks++;
    if (d !== 8'h00 || irq !== 1'b0) begin
      n_fail++; $display("FAIL match_clr got=%h/%b exp=00/0", d, irq);
    end
    idle(1);                           // E+12: match sets again
    bus_write(9'h1F6, 8'h01);          // E+13: clear
    bus_read(9'h1F6, d, h);            // E+14
    n_checks++;
    if (d !== 8'h00 || irq !== 1'b0) begin
      n_fail++; $display("FAIL match_clr2 got=%h/%b exp=00/0", d, irq);
    end
    idle(3);                           // E+15..E+17
    bus_write(9'h1F6, 8'h01);          // E+18: clear collides with match set
    bus_read(9'h1F6, d, h);            // E+19
    n_checks++;
    if (d !== 8'h01 || irq !== 1'b1) begin
      n_fail++; $display("FAIL clr_collide got=%h/%b exp=01/1", d, irq);
    end
  endtask

  task automatic test_wrap_and_load();
    logic [7:0] d; logic h;
    pulse_reset();
    bus_write(9'h1F4, 8'h34);
    bus_write(9'h1F5, 8'h12);
    bus_write(9'h1F2, 8'hFE);
    bus_write(9'h1F3, 8'hFF);
    bus_write(9'h1F0, 8'h05);          // edge E, no auto-reload
    bus_read(9'h1F2, d, h);            // E+1: 0xFFFE
    n_checks++;
    if (d !== 8'hFE) begin n_fail++; $display("FAIL wrap_lo0 got=%h exp=%h", d, 8'hFE); end
    bus_read(9'h1F3, d, h);
    n_checks++;
    if (d !== 8'hFF) begin n_fail++; $display("FAIL wrap_hi0 got=%h exp=%h", d, 8'hFF); end
    bus_read(9'h1F2, d, h);            // E+3: count after E+2 = 0x0000
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL wrap_lo1 got=%h exp=%h", d, 8'h00); end
    bus_read(9'h1F3, d, h);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL wrap_hi1 got=%h exp=%h", d, 8'h00); end
    bus_read(9'h1F2, d, h);            // E+5: 0x0002
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL wrap_lo2 got=%h exp=%h", d, 8'h02); end
    bus_read(9'h1F6, d, h);            // E+6
    n_checks++;
    if (d !== 8'h00 || irq !== 1'b0) begin
      n_fail++; $display("FAIL wrap_nomatch got=%h/%b exp=00/0", d, irq);
    end
    bus_write(9'h1F2, 8'h10);          // load on a tick edge: no increment
    bus_read(9'h1F2, d, h);
    n_checks++;
    if (d !== 8'h10) begin n_fail++; $display("FAIL load_collide got=%h exp=%h", d, 8'h10); end
    bus_read(9'h1F2, d, h);
    n_checks++;
    if (d !== 8'h11) begin n_fail++; $display("FAIL load_resume got=%h exp=%h", d, 8'h11); end
  endtask

  task automatic test_decode();
    logic [7:0] d; logic h;
    pulse_reset();
    bus_write(9'h1F2, 8'hFF);
    bus_write(9'h1F3, 8'hFF);          // count == CMP (0xFFFF)
    bus_write(9'h1F0, 8'h01);          // edge E
    bus_write(9'h1F0, 8'h00);          // E+1: tick sets match, then stop
    bus_write(9'h1E0, 8'h07);
    n_checks++;
    if (hit !== 1'b0 || data_out !== 8'h00) begin
      n_fail++; $display("FAIL wr_out_miss got=%b/%h exp=0/00", hit, data_out);
    end
    bus_write(9'h1E1, 8'hAA);
    bus_write(9'h1E6, 8'hFF);
    bus_write(9'h1F9, 8'hAA);
    n_checks++;
    if (hit !== 1'b1 || data_out !== 8'h00) begin
      n_fail++; $display("FAIL wr_out_hit got=%b/%h exp=1/00", hit, data_out);
    end
    bus_read(9'h1F6, d, h);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL dec_status got=%h exp=%h", d, 8'h01); end
    bus_read(9'h1F0, d, h);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL dec_ctrl got=%h exp=%h", d, 8'h00); end
    bus_read(9'h1F1, d, h);
    n_checks++;
    if (d !== 8'h00 || h !== 1'b1) begin
      n_fail++; $display("FAIL dec_pre got=%h/%b exp=00/1", d, h);
    end
    bus_read(9'h1E2, d, h);
    n_checks++;
    if (d !== 8'h00 || h !== 1'b0) begin
      n_fail++; $display("FAIL dec_miss got=%h/%b exp=00/0", d, h);
    end
    bus_read(9'h1F9, d, h);
    n_checks++;
    if (d !== 8'h00 || h !== 1'b1) begin
      n_fail++; $display("FAIL dec_rsvd got=%h/%b exp=00/1", d, h);
    end
    bus_write(9'h1F6, 8'h01);
    bus_read(9'h1F6, d, h);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL dec_clr got=%h exp=%h", d, 8'h00); end
    bus_write(9'h1F0, 8'hF8);
    bus_read(9'h1F0, d, h);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL ctrl_mask got=%h exp=%h", d, 8'h00); end
    bus_write(9'h1F1, 8'h5A);
    bus_read(9'h1F1, d, h);
    n_checks++;
    if (d !== 8'h5A) begin n_fail++; $display("FAIL pre_rdback got=%h exp=%h", d, 8'h5A); end
  endtask

  initial begin
    rw = 1'b0; address = 9'h000; data_in = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_prescale();
    test_compare_reload();
    test_wrap_and_load();
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_mmio.md
# timer_mmio

Memory-mapped 16-bit timer/compare peripheral that sits on the RAM-side port of the system bus as a responder, alongside the GPIO memory. Either core reaches it through the bus with ordinary byte reads and writes. It provides a prescaled up-counter, a compare match with optional auto-reload, a sticky match flag and an interrupt line. Read data is zero outside its address window so the bus can OR it with other responders.

## Interface
- BASE_ADDR, 9'h1F0, base of the 16-byte register window; low 4 bits must be 0
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rw  input  1  1 = write this cycle, 0 = read; bus holds 0 when idle
- address  input  9  byte address from bus
- data_in  input  8  write data from bus
- data_out  output  8  registered read data; 0 when last address was outside window
- hit  output  1  registered; 1 when last sampled address was inside window
- irq  output  1  registered: STATUS.match AND CTRL.irq_en

## Operation
- Window decode: sel = (address[8:4] == BASE_ADDR[8:4]); offset = address[3:0].
- Registers (offset):
  - 0x0 CTRL, RW: bit0 enable, bit1 auto_reload, bit2 irq_en; bits[7:3] read 0, writes ignored.
  - 0x1 PRESCALE, RW: one tick every PRESCALE+1 enabled cycles.
  - 0x2 COUNT_LO, RW: count[7:0]. Any read also latches count[15:8] into hi_shadow.
  - 0x3 COUNT_HI: read returns hi_shadow; write loads count[15:8].
  - 0x4 CMP_LO / 0x5 CMP_HI, RW: compare value.
  - 0x6 STATUS: bit0 match (sticky); writing 1 to bit0 clears it; other bits read 0.
  - 0x7–0xF: read 0, writes ignored.
- Prescaler: 8-bit pcnt. enable=0: pcnt forced to 0, count holds. enable=1: if pcnt == PRESCALE then pcnt <= 0 and tick=1, else pcnt <= pcnt+1.
- On tick: if count == CMP, set match; then if count == CMP and auto_reload, count <= 0, else count <= count+1 mod 2^16 (0xFFFF wraps to 0x0000, no flag).
- Write to COUNT_LO or COUNT_HI: loads that byte, other byte unchanged, pcnt <= 0; the load wins over a same-cycle tick (no increment, no match evaluation that cycle).
- STATUS write-1-clear and a same-cycle match set: set wins, match stays 1.
- PRESCALE or CMP writes take effect on the next cycle's comparison; pcnt not cleared.
- Writes outside the window: no effect. Reads have no side effect except the COUNT_LO hi_shadow latch.

## Timing
- Reset: CTRL=0, PRESCALE=0, count=0, CMP=16'hFFFF, match=0, pcnt=0, hi_shadow=0, data_out=0, hit=0, irq=0.
- Reads: address sampled on edge N; data_out/hit valid after edge N (one-cycle latency, same as the GPIO memory). A write cycle returns data_out=0, hit=sel.
- Writes: registers update on the edge where rw=1; reading the same register in cycle N+1 returns the new value.
- With PRESCALE=P and enable set at edge E, the first tick is at edge E+P+1; count increments on that edge.
- match sets on the tick edge where count==CMP; irq rises on the following edge (registered).
- Reset asserted mid-count: all state returns to reset values immediately, with no clock required.

## Test plan
- Reset: assert reset mid-count with PRESCALE=3, enable=1 -> data_out=0, irq=0; reads of 0x2/0x3 return 0x00; read of 0x4/0x5 returns 0xFF.
- Prescale: PRESCALE=3, enable=1, wait 40 cycles, read 0x2 then 0x3 -> count=0x000A; hi_shadow stays stable while count keeps running.
- Compare and auto-reload: CMP=0x0005, PRESCALE=0, CTRL=0x07 -> count sequence 0..5,0..; match set on the edge where count==5; irq high one cycle later; write 0x01 to 0x6 clears match and drops irq unless the clear coincides with a new match.
- Wrap: load count=0xFFFE, CMP=0x1234, auto_reload=0, PRESCALE=0 -> counts 0xFFFF, 0x0000, 0x0001; match stays 0.
- Collisions: write COUNT_LO=0x10 on a tick edge -> count[7:0]=0x10 with no increment. Write-1-clear STATUS on a match edge -> match=1.
- Decode: write 0xAA to 0x1E6 and 0x1F9 -> no register change; read 0x1E2 -> hit=0, data_out=0x00; read 0x1F1 -> hit=1.
